// File: rtl/apb_spi_sram_ctrl.sv
// apb_spi_sram_ctrl: APB slave that streams framed byte commands from a TX FIFO
// to a 23A1024-class SPI serial SRAM and collects read data into an RX FIFO.
// Ports:
//   clk, rst         - single clock, asynchronous active-high reset
//   paddr..pready    - zero-wait-state APB slave (word index in paddr[1:0])
//   miso/mosi/sck/cs - SPI mode 0 master pins, cs active low
//   HOLD_ENABLE      - SRAM HOLD_N, tied high
module apb_spi_sram_ctrl #(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned SCK_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        pen,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        miso,
  output logic        mosi,
  output logic        sck,
  output logic        cs,
  output logic        HOLD_ENABLE
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = $clog2(2 * SCK_DIV) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] HALF_END = DW'(SCK_DIV - 1);
  localparam logic [DW-1:0] HOLD_END = DW'(2 * SCK_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_LOW   = 3'd4;
  localparam logic [2:0] ST_HIGH  = 3'd5;
  localparam logic [2:0] ST_HOLD  = 3'd6;

  // APB decode
  logic w_acc, w_wr, w_rd, w_cmd;
  logic w_unused;
  assign w_acc  = psel & pen;
  assign w_wr   = w_acc & pwrite;
  assign w_rd   = w_acc & ~pwrite;
  assign w_cmd  = w_wr & (paddr[1:0] == 2'd0);
  assign pready = w_acc;
  assign HOLD_ENABLE = 1'b1;
  assign w_unused = &{1'b0, paddr[31:2], pwdata[31:9]};

  // TX FIFO (9-bit entries: header flag + byte)
  logic [8:0]    r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic          w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
  logic [8:0]    w_tx_head;

  // RX FIFO
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_cnt;
  logic          w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
  logic [7:0]    w_rx_head;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_tx_head  = r_tx_mem[r_tx_rp];
  assign w_rx_head  = r_rx_mem[r_rx_rp];
  assign w_tx_push  = w_wr & (paddr[1:0] == 2'd2) & ~w_tx_full;
  assign w_rx_pop   = w_rd & (paddr[1:0] == 2'd3) & ~w_rx_empty;

  // SPI engine registers
  logic [2:0]    r_state, w_state_n;
  logic [DW-1:0] r_div, w_div_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [6:0]    r_len, w_len_n;
  logic [6:0]    r_bidx, w_bidx_n;
  logic          r_is_wr, w_is_wr_n;
  logic [6:0]    r_tx_sr, w_tx_sr_n;
  logic [7:0]    r_rx_sr, w_rx_sr_n;
  logic          r_sck, w_sck_n;
  logic          r_cs, w_cs_n;
  logic          r_mosi, w_mosi_n;
  logic          w_busy;

  assign w_busy = (r_state != ST_IDLE);
  assign sck    = r_sck;
  assign cs     = r_cs;
  assign mosi   = r_mosi;

  // FIFO storage (no reset needed; validity tracked by pointers/counts)
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= pwdata[8:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sr;
  end

  // FIFO pointers and counts; simultaneous push and pop net to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  // Engine state register; cs is set asynchronously so reset drops the frame at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_len   <= '0;
      r_bidx  <= '0;
      r_is_wr <= 1'b0;
      r_tx_sr <= '0;
      r_rx_sr <= '0;
      r_sck   <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_div   <= w_div_n;
      r_bit   <= w_bit_n;
      r_len   <= w_len_n;
      r_bidx  <= w_bidx_n;
      r_is_wr <= w_is_wr_n;
      r_tx_sr <= w_tx_sr_n;
      r_rx_sr <= w_rx_sr_n;
      r_sck   <= w_sck_n;
      r_cs    <= w_cs_n;
      r_mosi  <= w_mosi_n;
    end
  end

  // Engine next-state: header parse, cs setup, mode-0 bit timing, cs hold
  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_bit_n   = r_bit;
    w_len_n   = r_len;
    w_bidx_n  = r_bidx;
    w_is_wr_n = r_is_wr;
    w_tx_sr_n = r_tx_sr;
    w_rx_sr_n = r_rx_sr;
    w_sck_n   = r_sck;
    w_cs_n    = r_cs;
    w_mosi_n  = r_mosi;
    w_tx_pop  = 1'b0;
    w_rx_push = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd) w_state_n = ST_HDR;
      end
      ST_HDR: begin
        if (w_tx_empty) begin
          w_state_n = ST_IDLE;
        end else begin
          // Stray data bytes and zero-length headers are popped and dropped
          w_tx_pop = 1'b1;
          if (w_tx_head[8] && (w_tx_head[6:0] != 7'd0)) begin
            w_len_n   = w_tx_head[6:0];
            w_is_wr_n = w_tx_head[7];
            w_bidx_n  = 7'd0;
            w_cs_n    = 1'b0;
            w_div_n   = '0;
            w_state_n = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (r_div == HALF_END) begin
          w_div_n   = '0;
          w_state_n = ST_LOAD;
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      ST_LOAD: begin
        // Underflow stalls here with cs low and sck idle
        if (!w_tx_empty) begin
          w_tx_pop  = 1'b1;
          w_mosi_n  = w_tx_head[7];
          w_tx_sr_n = w_tx_head[6:0];
          w_bit_n   = 3'd0;
          w_div_n   = '0;
          w_state_n = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_div == HALF_END) begin
          w_sck_n   = 1'b1;
          w_rx_sr_n = {r_rx_sr[6:0], miso};
          w_div_n   = '0;
          w_state_n = ST_HIGH;
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      ST_HIGH: begin
        if (r_div == HALF_END) begin
          w_sck_n = 1'b0;
          w_div_n = '0;
          if (r_bit == 3'd7) begin
            // Bytes 0..3 are instruction and address; only later bytes are data
            if (!r_is_wr && (r_bidx >= 7'd4)) w_rx_push = ~w_rx_full;
            w_bidx_n = r_bidx + 7'd1;
            if ((r_bidx + 7'd1) == r_len) begin
              w_cs_n    = 1'b1;
              w_mosi_n  = 1'b0;
              w_state_n = ST_HOLD;
            end else begin
              w_state_n = ST_LOAD;
            end
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_mosi_n  = r_tx_sr[6];
            w_tx_sr_n = {r_tx_sr[5:0], 1'b0};
            w_state_n = ST_LOW;
          end
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      ST_HOLD: begin
        if (r_div == HOLD_END) begin
          w_div_n   = '0;
          w_state_n = ST_HDR;
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cs_n    = 1'b1;
        w_sck_n   = 1'b0;
      end
    endcase
  end

  // APB read mux; zero outside the access phase
  logic [31:0] w_status, w_prdata;
  always_comb begin
    w_status        = '0;
    w_status[0]     = w_busy;
    w_status[1]     = w_tx_empty;
    w_status[2]     = w_tx_full;
    w_status[3]     = w_rx_empty;
    w_status[4]     = w_rx_full;
    w_status[13:8]  = 6'(r_tx_cnt);
    w_status[21:16] = 6'(r_rx_cnt);
  end

  always_comb begin
    w_prdata = '0;
    if (w_rd) begin
      case (paddr[1:0])
        2'd1:    w_prdata = w_status;
        2'd3:    if (!w_rx_empty) w_prdata = {24'b0, w_rx_head};
        default: w_prdata = '0;
      endcase
    end
  end
  assign prdata = w_prdata;

endmodule

// File: tb/tb_apb_spi_sram_ctrl.sv
// tb_apb_spi_sram_ctrl: scoreboard bench with a behavioural 23A1024 SRAM model.
module tb_apb_spi_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        pen = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        miso = 1'b0;
  logic        mosi, sck, cs, hold_en;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] rx_exp_q[$];
  int         win_q[$];
  time        gap_q[$];

  always #5 clk = ~clk;

  apb_spi_sram_ctrl #(.FIFO_DEPTH(32), .SCK_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel), .pen(pen),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .miso(miso), .mosi(mosi),
    .sck(sck), .cs(cs), .HOLD_ENABLE(hold_en)
  );

  // SPI monitor and SRAM model: records bytes, cs windows and gaps, serves reads
  logic       m_sck_q, m_cs_q;
  int         m_bitc = 0;
  logic [7:0] m_sr = '0;
  logic [7:0] m_instr = '0;
  logic [23:0] m_addr = '0;
  logic [7:0] m_mem [int];
  time        m_rise_t = 0;
  logic       m_seen_rise = 1'b0;

  always @(sck or cs) begin
    int k;
    int idx;
    logic [7:0] b;
    if (cs === 1'b0 && m_cs_q === 1'b1) begin
      m_bitc  = 0;
      m_instr = '0;
      if (m_seen_rise) gap_q.push_back($time - m_rise_t);
    end else if (cs === 1'b1 && m_cs_q === 1'b0) begin
      win_q.push_back(m_bitc);
      m_rise_t    = $time;
      m_seen_rise = 1'b1;
      miso        = 1'b0;
    end
    if (cs === 1'b0 && sck === 1'b1 && m_sck_q === 1'b0) begin
      m_sr   = {m_sr[6:0], mosi};
      m_bitc = m_bitc + 1;
      if (m_bitc % 8 == 0) begin
        obs_q.push_back(m_sr);
        if (m_bitc == 8) m_instr = m_sr;
        else if (m_bitc <= 32) m_addr = {m_addr[15:0], m_sr};
        else if (m_instr == 8'h02) m_mem[int'(m_addr) + m_bitc / 8 - 5] = m_sr;
      end
    end else if (cs === 1'b0 && sck === 1'b0 && m_sck_q === 1'b1) begin
      if (m_instr == 8'h03 && m_bitc >= 32) begin
        k   = m_bitc - 32;
        idx = int'(m_addr) + k / 8;
        b   = m_mem.exists(idx) ? m_mem[idx] : 8'h00;
        miso = b[7 - (k % 8)];
      end
    end
    m_sck_q = sck;
    m_cs_q  = cs;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = {30'b0, a}; pwdata = d;
    @(negedge clk);
    pen = 1'b1;
    @(negedge clk);
    psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = {30'b0, a};
    @(negedge clk);
    pen = 1'b1;
    #1 d = prdata;
    @(negedge clk);
    psel = 1'b0; pen = 1'b0;
  endtask

  // Push a TX entry; data bytes are expected on mosi later
  task automatic tx_push(input logic [8:0] e);
    apb_write(2'd2, {23'b0, e});
    if (!e[8]) exp_q.push_back(e[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    int n;
    n = 0;
    do begin
      apb_read(2'd1, st);
      n = n + 1;
    end while (st[0] && n < 3000);
    check_val(tag, 32'(st[0]), 32'd0);
  endtask

  task automatic drain_mosi(input string tag);
    check_val({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check_val(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic clear_mon();
    exp_q.delete(); obs_q.delete(); win_q.delete(); gap_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int i;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_cs", 32'(cs), 32'd1);
    check_val("rst_sck", 32'(sck), 32'd0);
    check_val("rst_mosi", 32'(mosi), 32'd0);
    check_val("rst_prdata", prdata, 32'd0);
    check_val("rst_pready", 32'(pready), 32'd0);
    check_val("hold_en", 32'(hold_en), 32'd1);
    rst = 1'b0;
    apb_read(2'd1, d);
    check_val("status_init", d, 32'h0000_000A);
    clear_mon();

    // Write frame: 8 bytes to SRAM address 0
    tx_push(9'h188);
    tx_push(9'h002); tx_push(9'h000); tx_push(9'h000); tx_push(9'h000);
    tx_push(9'h003); tx_push(9'h004); tx_push(9'h005); tx_push(9'h006);
    apb_write(2'd0, 32'd1);
    apb_read(2'd1, d);
    check_val("t1_busy", 32'(d[0]), 32'd1);
    wait_idle("t1_idle");
    apb_read(2'd1, d);
    check_val("t1_status", d, 32'h0000_000A);
    check_val("t1_nwin", 32'(win_q.size()), 32'd1);
    if (win_q.size() > 0) check_val("t1_edges", 32'(win_q[0]), 32'd64);
    drain_mosi("t1_mosi");
    clear_mon();

    // Read frame: bytes 4..7 land in RX
    tx_push(9'h108);
    tx_push(9'h003);
    for (i = 0; i < 7; i++) tx_push(9'h000);
    rx_exp_q.push_back(8'h03); rx_exp_q.push_back(8'h04);
    rx_exp_q.push_back(8'h05); rx_exp_q.push_back(8'h06);
    apb_write(2'd0, 32'd1);
    wait_idle("t2_idle");
    apb_read(2'd1, d);
    check_val("t2_rx_count", 32'(d[21:16]), 32'd4);
    for (i = 0; i < 4; i++) begin
      apb_read(2'd3, d);
      check_val("t2_rxdata", d, 32'(rx_exp_q.pop_front()));
    end
    apb_read(2'd3, d);
    check_val("t2_rx_empty_read", d, 32'd0);
    apb_read(2'd1, d);
    check_val("t2_rx_empty", 32'(d[3]), 32'd1);
    drain_mosi("t2_mosi");
    clear_mon();

    // Two queued frames under one CMD
    tx_push(9'h186); tx_push(9'h002); tx_push(9'h000); tx_push(9'h000);
    tx_push(9'h004); tx_push(9'h001); tx_push(9'h002);
    tx_push(9'h106); tx_push(9'h003); tx_push(9'h000); tx_push(9'h000);
    tx_push(9'h004); tx_push(9'h000); tx_push(9'h000);
    rx_exp_q.push_back(8'h01); rx_exp_q.push_back(8'h02);
    apb_write(2'd0, 32'd1);
    wait_idle("t3_idle");
    check_val("t3_nwin", 32'(win_q.size()), 32'd2);
    if (win_q.size() == 2) begin
      check_val("t3_edges0", 32'(win_q[0]), 32'd48);
      check_val("t3_edges1", 32'(win_q[1]), 32'd48);
    end
    check_val("t3_ngap", 32'(gap_q.size()), 32'd2);
    if (gap_q.size() == 2) check_val("t3_gap_ge_40ns", 32'(gap_q[1] >= 40), 32'd1);
    for (i = 0; i < 2; i++) begin
      apb_read(2'd3, d);
      check_val("t3_rxdata", d, 32'(rx_exp_q.pop_front()));
    end
    drain_mosi("t3_mosi");
    clear_mon();

    // Fill TX: 32 entries accepted, 33rd dropped
    tx_push(9'h19F);
    tx_push(9'h002); tx_push(9'h000); tx_push(9'h001); tx_push(9'h000);
    for (i = 0; i < 27; i++) tx_push(9'(8'h40 + i));
    apb_write(2'd2, 32'h0000_00AA);
    apb_read(2'd1, d);
    check_val("t4_full_status", d, 32'h0000_200C);
    apb_write(2'd0, 32'd1);
    apb_read(2'd1, d);
    check_val("t4_busy", 32'(d[0]), 32'd1);
    apb_write(2'd0, 32'd1);
    wait_idle("t4_idle");
    check_val("t4_nwin", 32'(win_q.size()), 32'd1);
    if (win_q.size() > 0) check_val("t4_edges", 32'(win_q[0]), 32'd248);
    drain_mosi("t4_mosi");
    win_q.delete();
    // The busy-time CMD must not linger: a new frame stays queued
    tx_push(9'h181); tx_push(9'h000);
    repeat (100) @(negedge clk);
    apb_read(2'd1, d);
    check_val("t4_no_restart", d, 32'h0000_0208);
    check_val("t4_no_win", 32'(win_q.size()), 32'd0);
    apb_write(2'd0, 32'd1);
    wait_idle("t4b_idle");
    drain_mosi("t4b_mosi");
    clear_mon();

    // Reset during the 3rd byte of a write frame
    tx_push(9'h186); tx_push(9'h002); tx_push(9'h000); tx_push(9'h000);
    tx_push(9'h008); tx_push(9'h0AA); tx_push(9'h0BB);
    apb_write(2'd0, 32'd1);
    for (i = 0; i < 3000 && cs !== 1'b0; i++) @(negedge clk);
    for (i = 0; i < 3000 && m_bitc < 18; i++) @(negedge clk);
    check_val("t5_reach_byte3", 32'(m_bitc >= 18 && m_bitc < 24), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("t5_cs_async", 32'(cs), 32'd1);
    check_val("t5_sck_async", 32'(sck), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apb_read(2'd1, d);
    check_val("t5_status", d, 32'h0000_000A);
    clear_mon();

    // Back-to-back APB writes to TXDATA
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = 32'd2;
    for (i = 0; i < 5; i++) begin
      case (i)
        0: pwdata = 32'h184;
        1: pwdata = 32'h002;
        4: pwdata = 32'h010;
        default: pwdata = 32'h000;
      endcase
      if (i > 0) exp_q.push_back(pwdata[7:0]);
      pen = 1'b0;
      #1 check_val("t6_pready_setup", 32'(pready), 32'd0);
      @(negedge clk);
      pen = 1'b1;
      #1 check_val("t6_pready_access", 32'(pready), 32'd1);
      @(negedge clk);
    end
    psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
    apb_read(2'd1, d);
    check_val("t6_tx_count", 32'(d[13:8]), 32'd5);
    apb_write(2'd0, 32'd1);
    wait_idle("t6_idle");
    check_val("t6_nwin", 32'(win_q.size()), 32'd1);
    if (win_q.size() > 0) check_val("t6_edges", 32'(win_q[0]), 32'd32);
    drain_mosi("t6_mosi");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
